// File: rtl/lcd_init_sequencer_pkg.sv
// rtl/lcd_init_sequencer_pkg.sv - shared display state encoding and default timing parameters
package lcd_init_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HWRST_LOW,
    HWRST_WAIT,
    FETCH,
    SEND,
    DELAY,
    DONE
  } lcd_state_t;

  localparam int DEF_INIT_LIST_LENGTH = 47;
  localparam int DEF_MAX_DELAY_COUNT  = 2000000;
  localparam int DEF_RST_LOW_CYCLES   = 500;
  localparam int DEF_RST_WAIT_CYCLES  = 6000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_init_sequencer_cycle_down_counter.sv
// rtl/lcd_init_sequencer_cycle_down_counter.sv - loadable down counter that saturates at zero
module cycle_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lcd_init_sequencer.sv
// rtl/lcd_init_sequencer.sv - panel hardware reset then ROM-driven SPI init byte sequencer
module lcd_init_sequencer
  import lcd_init_sequencer_pkg::*;
#(
  parameter int  INIT_LIST_LENGTH = DEF_INIT_LIST_LENGTH,
  parameter int  MAX_DELAY_COUNT  = DEF_MAX_DELAY_COUNT,
  parameter int  RST_LOW_CYCLES   = DEF_RST_LOW_CYCLES,
  parameter int  RST_WAIT_CYCLES  = DEF_RST_WAIT_CYCLES,
  localparam int AW = (INIT_LIST_LENGTH > 1) ? $clog2(INIT_LIST_LENGTH) : 1,
  localparam int DW = (MAX_DELAY_COUNT > 1) ? $clog2(MAX_DELAY_COUNT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [8:0]    rom_data,
  input  logic [DW-1:0] rom_delay,
  output logic          spi_valid,
  input  logic          spi_ready,
  output logic [7:0]    spi_data,
  output logic          spi_dc,
  output logic          lcd_rst_n,
  output logic          busy,
  output logic          done
);

  localparam int CW = max3(DW, $clog2(RST_WAIT_CYCLES + 1), $clog2(RST_LOW_CYCLES + 1));

  // Loaded with N-1 so a phase exits on the zero flag after exactly N clocks.
  localparam logic [CW-1:0] RST_LOW_LOAD  = CW'((RST_LOW_CYCLES > 0) ? RST_LOW_CYCLES - 1 : 0);
  localparam logic [CW-1:0] RST_WAIT_LOAD = CW'((RST_WAIT_CYCLES > 0) ? RST_WAIT_CYCLES - 1 : 0);
  localparam logic [AW-1:0] LAST_ADDR     = AW'(INIT_LIST_LENGTH - 1);

  lcd_state_t    state_q, state_d;
  logic          cnt_load, cnt_enable, cnt_zero;
  logic [CW-1:0] cnt_load_value;
  logic [DW-1:0] delay_load;
  logic          addr_clear, addr_inc, fetch_latch, advance;

  cycle_down_counter #(.WIDTH(CW)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .enable     (cnt_enable),
    .load_value (cnt_load_value),
    .zero       (cnt_zero)
  );

  assign delay_load = rom_delay - DW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rom_addr <= '0;
      spi_data <= '0;
      spi_dc   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (addr_clear) begin
        rom_addr <= '0;
      end else if (addr_inc) begin
        rom_addr <= rom_addr + AW'(1);
      end
      if (fetch_latch) begin
        spi_dc   <= rom_data[8];
        spi_data <= rom_data[7:0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_load       = 1'b0;
    cnt_enable     = 1'b0;
    cnt_load_value = '0;
    addr_clear     = 1'b0;
    addr_inc       = 1'b0;
    fetch_latch    = 1'b0;
    advance        = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d        = HWRST_LOW;
          cnt_load       = 1'b1;
          cnt_load_value = RST_LOW_LOAD;
          addr_clear     = 1'b1;
        end
      end
      HWRST_LOW: begin
        if (cnt_zero) begin
          state_d        = HWRST_WAIT;
          cnt_load       = 1'b1;
          cnt_load_value = RST_WAIT_LOAD;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      HWRST_WAIT: begin
        if (cnt_zero) begin
          state_d = FETCH;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      FETCH: begin
        state_d     = SEND;
        fetch_latch = 1'b1;
      end
      SEND: begin
        if (spi_ready) begin
          if (rom_delay != '0) begin
            state_d        = DELAY;
            cnt_load       = 1'b1;
            cnt_load_value = CW'(delay_load);
          end else begin
            advance = 1'b1;
          end
        end
      end
      DELAY: begin
        if (cnt_zero) begin
          advance = 1'b1;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The last entry finishes in DONE with rom_addr parked, so the address never wraps.
    if (advance) begin
      if (rom_addr == LAST_ADDR) begin
        state_d = DONE;
      end else begin
        state_d  = FETCH;
        addr_inc = 1'b1;
      end
    end
  end

  assign spi_valid = (state_q == SEND);
  assign lcd_rst_n = (state_q != HWRST_LOW);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);

endmodule

// File: doc/lcd_init_sequencer.md
LCD_INIT_SEQUENCER -- requirements
Module: lcd_init_sequencer

Interface
REQ-001 The block SHALL have the parameter INIT_LIST_LENGTH, default 47: number of ROM entries; ROM address width AW = $clog2(INIT_LIST_LENGTH).
REQ-002 The block SHALL have the parameter MAX_DELAY_COUNT, default 2000000: delay ROM range; delay width DW = $clog2(MAX_DELAY_COUNT).
REQ-003 The block SHALL have the parameter RST_LOW_CYCLES, default 500: panel reset assertion length in clocks.
REQ-004 The block SHALL have the parameter RST_WAIT_CYCLES, default 6000: wait after panel reset release in clocks.
REQ-005 The block SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset (one clock; reset asynchronous active-high).
REQ-007 The block SHALL have port start, input, 1 bit: single-cycle request to run the init sequence.
REQ-008 The block SHALL have port rom_addr, output, AW bits: address shared by the command ROM and the delay ROM.
REQ-009 The block SHALL have port rom_data, input, 9 bits: [8] = D/C flag (0 command, 1 data), [7:0] = byte.
REQ-010 The block SHALL have port rom_delay, input, DW bits: post-transfer delay in clocks for rom_addr.
REQ-011 The block SHALL have port spi_valid, output, 1 bit: byte offered to the SPI byte transmitter.
REQ-012 The block SHALL have port spi_ready, input, 1 bit: transmitter accepts the byte this cycle.
REQ-013 The block SHALL have port spi_data, output, 8 bits: byte to send.
REQ-014 The block SHALL have port spi_dc, output, 1 bit: D/C line value for spi_data.
REQ-015 The block SHALL have port lcd_rst_n, output, 1 bit: panel hardware reset, active-low.
REQ-016 The block SHALL have port busy, output, 1 bit: sequence in progress.
REQ-017 The block SHALL have port done, output, 1 bit: sequence completed; sticky until next start or reset.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, HWRST_LOW, HWRST_WAIT, FETCH, SEND, DELAY, DONE.
REQ-019 In IDLE or DONE, start=1 SHALL move the FSM to HWRST_LOW next cycle, clear done, set busy, and drive lcd_rst_n=0.
REQ-020 start SHALL be ignored in all other states.
REQ-021 HWRST_LOW SHALL last exactly RST_LOW_CYCLES clocks with lcd_rst_n=0, then enter HWRST_WAIT with lcd_rst_n=1.
REQ-022 HWRST_WAIT SHALL last exactly RST_WAIT_CYCLES clocks, then enter FETCH with rom_addr=0.
REQ-023 FETCH SHALL last one clock and register spi_data=rom_data[7:0] and spi_dc=rom_data[8] on exit to SEND.
REQ-024 In SEND, spi_valid SHALL be 1, and spi_data and spi_dc SHALL be held stable until the transfer cycle (spi_valid & spi_ready).
REQ-025 On the transfer cycle, spi_valid SHALL deassert next cycle.
REQ-026 On the transfer cycle, rom_delay≠0 SHALL cause entry to DELAY for exactly rom_delay clocks.
REQ-027 On the transfer cycle, rom_delay=0 SHALL cause the block to advance.
REQ-028 Advance SHALL go to DONE if rom_addr = INIT_LIST_LENGTH-1, else increment rom_addr and go to FETCH.
REQ-029 DELAY completion SHALL advance per REQ-028.
REQ-030 DONE SHALL hold done=1 and busy=0; rom_addr SHALL hold its last value.
REQ-031 spi_valid SHALL be 0 outside SEND.
REQ-032 rom_addr SHALL never wrap and never exceed INIT_LIST_LENGTH-1.
REQ-033 Counters SHALL be width max(DW, $clog2(RST_WAIT_CYCLES+1), $clog2(RST_LOW_CYCLES+1)) and SHALL count down to 0 without underflow.
REQ-034 Minimum per-byte period with spi_ready tied high and zero delay SHALL be 2 clocks (FETCH + SEND).

Reset
REQ-035 Asserting rst at any time, including mid-SEND or mid-DELAY, SHALL immediately force: IDLE, rom_addr=0, spi_valid=0, spi_data=0, spi_dc=0, lcd_rst_n=1, busy=0, done=0, counters=0.
REQ-036 After rst release, the block SHALL wait in IDLE for start.

Structure
REQ-037 The state encoding and the default parameter values SHALL live in the shared display package/include used by the ROM and SPI blocks.
REQ-038 One sub-module SHALL be used, cycle_down_counter (load, enable, zero flag), shared by the reset and delay phases.

Verification
REQ-039 Reset, start pulse, spi_ready=1 -> lcd_rst_n low exactly 500 clocks, high then 6000 clocks idle, then 47 transfers; first transfer 0xCB dc=0, second 0x39 dc=1; done=1 after the 47th.
REQ-040 Simulation delays (addr 9 = 5, addr 44 = 50) -> gap from transfer 9 (0x30) to next spi_valid ≥ 5+1 clocks; after 0x11 the gap before 0x29 is ≥ 50+1 clocks.
REQ-041 spi_ready held low for 10 cycles during SEND of byte 0xE8 -> spi_valid, spi_data=0xE8 and spi_dc=0 are stable for all 10 cycles; exactly one transfer is counted.
REQ-042 start pulsed during HWRST_WAIT and during DELAY -> no restart; total transfer count stays 47.
REQ-043 rst asserted during DELAY after addr 44 -> same-cycle busy=0, spi_valid=0, lcd_rst_n=1; new start reruns from 0xCB.
